// File: rtl/sd_access_pkg.sv
// Shared request-type constants and FSM encodings for the
// scoreboard memory access blocks.
package sd_access_pkg;

    localparam logic SD_REQ_RD = 1'b0;
    localparam logic SD_REQ_WR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_RESP = 2'b10
    } sd_state_e;

endpackage

// File: rtl/sd_mem64_array.sv
// 64-bit word storage with a per-bit masked write port and a
// registered (one-cycle) read port. Contents are never reset.
module sd_mem64_array #(
    parameter int s_asz = 11
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [s_asz-1:0] waddr_i,
    input  logic [63:0]      wmask_i,
    input  logic [63:0]      wdata_i,
    input  logic             re_i,
    input  logic [s_asz-1:0] raddr_i,
    output logic [63:0]      rdata_o
);

    logic [63:0] mem_q [1<<s_asz];
    logic [63:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= (mem_q[waddr_i] & ~wmask_i)
                            | (wdata_i & wmask_i);
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sd_mem64_resp.sv
// Request/response front end for the 64-bit scoreboard memory:
// writes complete in IDLE, reads return one response after two edges.
module sd_mem64_resp
    import sd_access_pkg::*;
#(
    parameter int s_asz = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             z2s_srdy,
    output logic             z2s_drdy,
    input  logic             z2s_req_type,
    input  logic [63:0]      z2s_mask,
    input  logic [63:0]      z2s_data,
    input  logic [s_asz-1:0] z2s_itemid,
    output logic             s2z_srdy,
    input  logic             s2z_drdy,
    output logic [63:0]      s2z_data
);

    sd_state_e        state_q;
    logic [s_asz-1:0] addr_q;
    logic             wait_q;
    logic             srdy_q;
    logic [63:0]      resp_q;
    logic [63:0]      rd_data;
    logic             wr_en;
    logic             rd_en;

    assign z2s_drdy = (state_q == ST_IDLE);
    assign wr_en    = z2s_srdy & z2s_drdy & (z2s_req_type == SD_REQ_WR);
    // First RD cycle issues the array read; second captures its output.
    assign rd_en    = (state_q == ST_RD) & ~wait_q;

    sd_mem64_array #(
        .s_asz (s_asz)
    ) u_array (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (z2s_itemid),
        .wmask_i (z2s_mask),
        .wdata_i (z2s_data),
        .re_i    (rd_en),
        .raddr_i (addr_q),
        .rdata_o (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wait_q  <= 1'b0;
            srdy_q  <= 1'b0;
            resp_q  <= 64'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (z2s_srdy && z2s_req_type == SD_REQ_RD) begin
                        addr_q  <= z2s_itemid;
                        wait_q  <= 1'b0;
                        state_q <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (wait_q) begin
                        resp_q  <= rd_data;
                        wait_q  <= 1'b0;
                        srdy_q  <= 1'b1;
                        state_q <= ST_RESP;
                    end else begin
                        wait_q <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (s2z_drdy) begin
                        srdy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    wait_q  <= 1'b0;
                    srdy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s2z_srdy = srdy_q;
    assign s2z_data = resp_q;

endmodule
